// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;

  // Instruction addresses are word aligned; the low two bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/pc_reg_ar.sv
// Program counter register: async active-low reset to RESET_PC,
// load (redirect) has priority over increment, otherwise hold.
module pc_reg_ar
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: load over increment over hold; increment wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read at a time,
// hands instruction+PC to decode, and handles redirects and stalls.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] pc_value
);

  fetch_state_e state_q;
  logic         drop_q;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;

  fetch_state_e launch_state;
  logic [31:0]  redirect_pc_aligned;
  logic         pc_inc;

  // Where to go when a new fetch could start: stall holds us in IDLE.
  assign launch_state        = stall ? IDLE : REQ;
  assign redirect_pc_aligned = word_align(redirect_pc);

  // PC advances only when a live (not dropped) response is captured without a redirect.
  assign pc_inc = !redirect_valid && (state_q == WAIT) && imem_rsp_valid && !drop_q;

  pc_reg_ar #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (redirect_valid),
    .load_pc_i (redirect_pc_aligned),
    .inc_i     (pc_inc),
    .pc_o      (pc_value)
  );

  // Fetch FSM with drop flag and registered decode-side outputs; redirect has priority.
  // A redirect after the request is accepted cannot cancel it, so the reply is
  // marked for discard via drop_q instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= launch_state;
        end
        REQ: begin
          if (imem_req_ready) begin
            state_q <= WAIT;
            if (redirect_valid) begin
              drop_q <= 1'b1;
            end
          end else if (redirect_valid) begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            if (imem_rsp_valid) begin
              drop_q  <= 1'b0;
              state_q <= launch_state;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= launch_state;
            end else begin
              if_valid_q <= 1'b1;
              if_instr_q <= imem_rsp_data;
              if_pc_q    <= pc_value;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid || if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= launch_state;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_value;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected requests and deliveries are
// queued by the stimulus thread and popped by monitors on DUT handshakes.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] pc_value;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_req    = 0;
  int unsigned n_if     = 0;
  int          rsp_delay = 1;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_if_pc_q[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (32'd4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .pc_value       (pc_value)
  );

  // Memory content model: instruction word derived from its address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start exactly one fetch from IDLE; the DUT is in REQ on return.
  task automatic launch();
    stall = 1'b0;
    tick();
    stall = 1'b1;
  endtask

  task automatic wait_if(input int unsigned n);
    int unsigned k = 0;
    while (n_if < n && k < 60) begin
      tick();
      k++;
    end
    if (n_if < n) begin
      n_checks++;
      $display("FAIL wait_if: handshakes %0d expected %0d", n_if, n);
    end
  endtask

  // Request monitor: every accepted request is checked against the queue.
  initial forever begin
    @(negedge clk);
    if (reset_n && imem_req_valid && imem_req_ready) begin
      n_req++;
      if (exp_req_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got addr %h expected none", imem_req_addr);
      end else begin
        chk("req_addr", imem_req_addr, exp_req_q.pop_front());
      end
    end
  end

  // Decode-side monitor: every if handshake is checked against the queue.
  initial forever begin
    @(negedge clk);
    if (reset_n && if_valid && if_ready) begin
      n_if++;
      if (exp_if_pc_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_if: got pc %h expected none", if_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_if_pc_q.pop_front();
        chk("if_pc", if_pc, epc);
        chk("if_instr", if_instr, instr_of(epc));
      end
    end
  end

  // Memory responder: one response pulse rsp_delay cycles after acceptance.
  initial begin
    logic [31:0] a;
    int          d;
    forever begin
      @(negedge clk);
      if (reset_n && imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        d = rsp_delay;
        tick();
        repeat (d - 1) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(a);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_pc", pc_value, 32'd0);

    // 1: back-to-back fetches 0,4,8
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    exp_if_pc_q.push_back(32'h0);
    exp_if_pc_q.push_back(32'h4);
    exp_if_pc_q.push_back(32'h8);
    @(posedge clk);
    #1;
    reset_n        = 1'b1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_if(2);
    stall = 1'b1;
    wait_if(3);
    tick();
    tick();
    @(negedge clk);
    chk("s1_idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("s1_pc", pc_value, 32'hC);
    chk("s1_req_count", n_req, 32'd3);

    // 2: request held stable while ready is low
    @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    exp_req_q.push_back(32'hC);
    exp_if_pc_q.push_back(32'hC);
    launch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s2_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("s2_req_addr", imem_req_addr, 32'hC);
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    wait_if(4);
    tick();
    @(negedge clk);
    chk("s2_single_accept", n_req, 32'd4);
    chk("s2_pc", pc_value, 32'h10);

    // 3: redirect in WAIT, stale response dropped
    @(posedge clk);
    #1;
    rsp_delay = 2;
    exp_req_q.push_back(32'h10);
    exp_req_q.push_back(32'h100);
    exp_if_pc_q.push_back(32'h100);
    launch();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    @(negedge clk);
    chk("s3_pc_redirected", pc_value, 32'h100);
    chk("s3_no_if_valid", {31'd0, if_valid}, 32'd0);
    @(posedge clk);
    #1;
    stall     = 1'b1;
    rsp_delay = 1;
    wait_if(5);
    tick();
    @(negedge clk);
    chk("s3_pc", pc_value, 32'h104);

    // 4: decode back-pressure in HOLD
    @(posedge clk);
    #1;
    if_ready = 1'b0;
    exp_req_q.push_back(32'h104);
    exp_if_pc_q.push_back(32'h104);
    launch();
    for (int k = 0; k < 20 && !if_valid; k++) @(negedge clk);
    chk("s4_if_valid_seen", {31'd0, if_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("s4_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("s4_hold_pc", if_pc, 32'h104);
      chk("s4_hold_instr", if_instr, instr_of(32'h104));
      chk("s4_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    if_ready = 1'b1;
    wait_if(6);
    tick();
    @(negedge clk);
    chk("s4_req_count", n_req, 32'd7);

    // 5: misaligned redirect target and PC wrap
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("s5_aligned_pc", pc_value, 32'h200);
    chk("s5_stalled_idle", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_if_pc_q.push_back(32'hFFFF_FFFC);
    launch();
    wait_if(7);
    tick();
    @(negedge clk);
    chk("s5_wrap_pc", pc_value, 32'h0);

    // 6: reset while waiting for a response
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 2;
    exp_req_q.push_back(32'h40);
    launch();
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("s6_rst_pc", pc_value, 32'h0);
    chk("s6_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("s6_rst_if_instr", if_instr, 32'h0);
    chk("s6_rst_if_pc", if_pc, 32'h0);
    tick();
    @(negedge clk);
    chk("s6_rsp_during_reset", {31'd0, imem_rsp_valid}, 32'd1);
    chk("s6_rst_if_valid", {31'd0, if_valid}, 32'd0);
    @(posedge clk);
    #1;
    tick();
    reset_n   = 1'b1;
    rsp_delay = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("s6_post_if_valid", {31'd0, if_valid}, 32'd0);
    chk("s6_post_pc", pc_value, 32'h0);
    chk("s6_post_if_count", n_if, 32'd7);
    @(posedge clk);
    #1;
    exp_req_q.push_back(32'h0);
    exp_if_pc_q.push_back(32'h0);
    launch();
    wait_if(8);
    tick();
    @(negedge clk);
    chk("s6_recover_pc", pc_value, 32'h4);

    chk("req_queue_empty", exp_req_q.size(), 32'd0);
    chk("if_queue_empty", exp_if_pc_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
